disp_scan4: RTL and testbench
=============================

DISP_SCAN4 -- requirements
Module: disp_scan4

Interface
REQ-001 Parameter: DIV, 100000, refresh clock cycles per digit slot (legal range 2..2^20).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: en  input  1  scan enable; 0 freezes the scan and blanks the display.
REQ-005 Port: load  input  1  request to capture value; qualified by ready.
REQ-006 Port: value  input  16  four BCD nibbles; [3:0] is digit 0 (rightmost, least significant), [15:12] is digit 3.
REQ-007 Port: ready  output  1  1 = no update pending, load accepted.
REQ-008 Port: err  output  1  one-cycle pulse when a load is rejected for a non-BCD nibble.
REQ-009 Port: digit  output  4  BCD code of the digit in the current slot; feeds the 7-segment decoder input.
REQ-010 Port: sel  output  4  active-low one-hot digit select; bit i low = digit i lit.

Function
REQ-011 Refresh counter cnt counts 0..DIV-1 while en=1; tick = (cnt==DIV-1); cnt wraps to 0 on tick.
REQ-012 Slot index idx (2 bits) increments on tick, wrapping from 3 to 0.
REQ-013 digit = active[4*idx+3 : 4*idx]; sel = ~(4'b0001 << idx); both update on the same edge as idx.
REQ-014 Accept condition = load & ready & every nibble of value <= 9; on accept, shadow <= value, pending <= 1, and ready = 0 from the next cycle.
REQ-015 load with ready=1 and any nibble > 9: shadow unchanged; err = 1 for exactly the next cycle; ready stays 1.
REQ-016 load with ready=0: ignored; no err pulse.
REQ-017 Transfer occurs on a tick with idx==3 and pending=1 (frame boundary, no tearing): active <= shadow, pending <= 0, ready = 1 from the next cycle.
REQ-018 With en=0: cnt and idx hold; sel = 4'hF; digit holds; loads follow REQ-014..016.
REQ-019 With en=0 and pending=1: transfer occurs on the next clock edge, without waiting for a frame boundary.
REQ-020 When en returns to 1, scanning resumes from the held cnt and idx; no slot is skipped.
REQ-021 Accept and transfer are never in the same cycle, because accept requires pending=0.

Reset
REQ-022 When rst_n=0 at a rising edge, state is set as follows: cnt=0, idx=0, active=0, shadow=0, pending=0.
REQ-023 Outputs after reset: ready=1, err=0, digit=0, sel=4'hE.
REQ-024 Reset asserted mid-operation discards any pending update; the first tick after reset release occurs DIV cycles later.

Configuration
REQ-025 The macro LZ_BLANK_EN controls leading-zero blanking.
REQ-026 LZ_BLANK_EN defined: during the slot for digit i (i = 1..3), sel = 4'hF when active nibbles i..3 are all zero; digit 0 is never blanked; digit output is unchanged.
REQ-027 LZ_BLANK_EN undefined: all four digits are always lit per REQ-013 and REQ-018.

Verification (DIV=4)
REQ-028 Reset, en=1, observe 16 cycles -> sel sequence E,D,B,7, each held 4 cycles; digit=0 throughout; ready=1.
REQ-029 load=1, value=16'h1234, ready=1 -> ready=0 the next cycle; at the first idx 3->0 tick, active=1234; ready=1 the cycle after; digit sequence 4,3,2,1.
REQ-030 load=1, value=16'h12A4 -> err=1 for exactly one cycle; ready stays 1; active unchanged.
REQ-031 Accepted load followed by load=1, value=16'h9999 while ready=0 -> second load ignored; after transfer, digits equal the first value.
REQ-032 en=0 with pending=1 -> sel=4'hF, transfer on the next edge, ready=1; en=1 -> scan resumes at the held idx.
REQ-033 LZ_BLANK_EN defined, value=16'h0050 -> sel=F during slots 3 and 2, D during slot 1, E during slot 0.

Source files
------------

// File: rtl/disp_scan4.sv
// Four-digit multiplexed BCD display scanner with a frame-synchronous shadow register.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module disp_scan4 #(
  parameter int DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  output logic        err,
  output logic [3:0]  digit,
  output logic [3:0]  sel
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic tick;
  logic value_bcd;
  logic accept;
  logic reject;
  logic xfer;
  logic blank;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_comb begin
    value_bcd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (value[4*i +: 4] > 4'd9) value_bcd = 1'b0;
    end
  end

  assign accept = load && !pending && value_bcd;
  assign reject = load && !pending && !value_bcd;

  // Update only at a frame boundary so a frame never mixes old and new digits;
  // while frozen there is no frame to tear, so transfer immediately.
  assign xfer = pending && (!en || (tick && idx == 2'd3));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd0;
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) idx <= idx + 2'd1;
      end
      err <= reject;
      if (xfer) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

`ifdef LZ_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (active[15:4] == 12'h000);
      2'd2:    blank = (active[15:8] == 8'h00);
      2'd3:    blank = (active[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign ready = !pending;
  assign digit = active[{idx, 2'b00} +: 4];
  assign sel   = (!en || blank) ? 4'hF : ~(4'b0001 << idx);

endmodule

// File: tb/tb_disp_scan4.sv
// Self-checking bench for disp_scan4 (DIV=4): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_disp_scan4;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        ready;
  logic        err;
  logic [3:0]  digit;
  logic [3:0]  sel;

  int errors = 0;
  int checks = 0;
  bit check_on = 1'b0;

  // behavioural model: position in the scan is simply the number of enabled cycles since reset
  int      m_phase;
  int      m_active;
  int      m_shadow;
  bit      m_pending;
  bit      m_err;

  disp_scan4 #(.DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .value (value),
    .ready (ready),
    .err   (err),
    .digit (digit),
    .sel   (sel)
  );

  always #5 clk = ~clk;

  function automatic bit is_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_idx();
    return (m_phase / DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_sel(input logic en_now);
    int  i;
    bit  blank;
    i = m_idx();
    blank = 1'b0;
`ifdef LZ_BLANK_EN
    if (i > 0 && (m_active >> (4 * i)) == 0) blank = 1'b1;
`endif
    if (!en_now || blank) return 4'hF;
    return 4'(~(1 << i));
  endfunction

  always @(posedge clk) begin
    bit acc, rej, xf;
    if (!rst_n) begin
      m_phase = 0; m_active = 0; m_shadow = 0; m_pending = 0; m_err = 0;
    end else begin
      acc = load && !m_pending && is_bcd(value);
      rej = load && !m_pending && !is_bcd(value);
      xf  = m_pending && (!en || (m_phase % FRAME) == FRAME - 1);
      m_err = rej;
      if (en) m_phase++;
      if (xf) begin
        m_active = m_shadow; m_pending = 0;
      end
      if (acc) begin
        m_shadow = int'(value); m_pending = 1;
      end
    end
  end

  // the single per-cycle compare against the model
  always @(negedge clk) begin
    logic [3:0] e_dig, e_sel;
    if (check_on) begin
      e_dig = 4'((m_active >> (4 * m_idx())) & 15);
      e_sel = exp_sel(en);
      checks++;
      if (ready !== !m_pending || err !== m_err || digit !== e_dig || sel !== e_sel) begin
        errors++;
        $display("FAIL model t=%0t got rdy=%b err=%b dig=%h sel=%h want rdy=%b err=%b dig=%h sel=%h",
                 $time, ready, err, digit, sel, !m_pending, m_err, e_dig, e_sel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout got ready=%b want 1", name, ready);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sel_seq [4];
    sel_seq[0] = 4'hE; sel_seq[1] = 4'hD; sel_seq[2] = 4'hB; sel_seq[3] = 4'h7;
    rst_n = 1'b0; en = 1'b1; load = 1'b0; value = 16'h0000;
    step();
    check_on = 1'b1;
    do_reset();

    // reset outputs and the empty scan pattern
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_err", 16'(err), 16'h0);
    for (int k = 0; k < 16; k++) begin
      chk("scan_sel", 16'(sel), 16'(sel_seq[k / 4]));
      chk("scan_digit", 16'(digit), 16'h0);
      step();
    end

    // accepted load shows up at the frame boundary, rightmost digit first
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    chk("load_ready_low", 16'(ready), 16'h0);
    wait_ready("xfer1");
    for (int k = 0; k < 4; k++) begin
      chk("seq1234", 16'(digit), 16'(4 - k));
      repeat (DIV) step();
    end

    // non-BCD load: one-cycle err, nothing captured
    load = 1'b1; value = 16'h12A4;
    step();
    load = 1'b0;
    chk("bad_err", 16'(err), 16'h1);
    chk("bad_ready", 16'(ready), 16'h1);
    step();
    chk("bad_err_clear", 16'(err), 16'h0);

    // load while busy is dropped
    load = 1'b1; value = 16'h5678;
    step();
    value = 16'h9999;
    step();
    chk("busy_no_err", 16'(err), 16'h0);
    load = 1'b0;
    wait_ready("xfer2");
    for (int k = 0; k < 4; k++) begin
      chk("seq5678", 16'(digit), 16'(8 - k));
      repeat (DIV) step();
    end

    // freeze with an update pending: immediate transfer, blanked, then resume
    repeat (5) step();
    load = 1'b1; value = 16'h4321;
    step();
    load = 1'b0; en = 1'b0;
    #1;
    chk("frz_sel", 16'(sel), 16'hF);
    chk("frz_pending", 16'(ready), 16'h0);
    step();
    chk("frz_xfer_ready", 16'(ready), 16'h1);
    repeat (3) step();
    en = 1'b1;
    repeat (20) step();

    // reset mid-update discards the pending value
    load = 1'b1; value = 16'h8888;
    step();
    load = 1'b0;
    do_reset();
    chk("mid_rst_ready", 16'(ready), 16'h1);
    chk("mid_rst_digit", 16'(digit), 16'h0);
    repeat (DIV) step();
    chk("first_tick_sel", 16'(sel), 16'hD);

`ifdef LZ_BLANK_EN
    load = 1'b1; value = 16'h0050;
    step();
    load = 1'b0;
    wait_ready("xfer_lz");
    for (int k = 0; k < 4; k++) begin
      chk("lz_sel", 16'(sel), (k == 0) ? 16'hE : (k == 1) ? 16'hD : 16'hF);
      repeat (DIV) step();
    end
`endif

    // randomized traffic, checked by the per-cycle model compare
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++)
        value[4*i +: 4] = ($urandom_range(0, 9) != 0) ? 4'($urandom_range(0, 9))
                                                       : 4'($urandom_range(10, 15));
      step();
    end
    load = 1'b0; rst_n = 1'b1; en = 1'b1;
    step();
    check_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
